// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: FSM states, frame constants
// and small helpers used by the loader and its timeout sub-block.
package program_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_HI = 4'd1,
        ST_LEN_LO = 4'd2,
        ST_OPC_HI = 4'd3,
        ST_OPC_LO = 4'd4,
        ST_OPR_HI = 4'd5,
        ST_OPR_LO = 4'd6,
        ST_WRITE  = 4'd7,
        ST_CHECK  = 4'd8,
        ST_DONE   = 4'd9,
        ST_ERROR  = 4'd10
    } state_e;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam int         RECORD_BYTES  = 4;
    localparam int         PARTIAL_BITS  = (RECORD_BYTES - 1) * 8;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // States in which a silent sender is treated as a stalled frame.
    function automatic logic is_timed(input state_e s);
        case (s)
            ST_LEN_HI, ST_LEN_LO, ST_OPC_HI, ST_OPC_LO,
            ST_OPR_HI, ST_OPR_LO, ST_CHECK: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter: cleared on demand, advances while enabled, and flags
// expiry on the cycle that would bring the count up to TIMEOUT.
module loader_timeout #(
    parameter int TIMEOUT = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Idle-cycle count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = i_enable && !i_clear && (r_count >= LAST);

endmodule

// File: rtl/program_loader.sv
// Receives a framed program over a byte stream, writes each record to
// instruction memory and releases the CPU only when the frame checksum is good.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0] MAGIC   = MAGIC_DEFAULT,
    parameter int         TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_opcode,
    output logic [15:0] mem_operand,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    state_e                  r_state, w_state_next, w_hold_state;
    logic [7:0]              r_chk, w_chk_next;
    logic [15:0]             r_remaining, w_remaining_next;
    logic [PARTIAL_BITS-1:0] r_rec, w_rec_next;
    logic                    r_mem_we, w_mem_we_next;
    logic [15:0]             r_addr, w_addr_next;
    logic [15:0]             r_opcode, w_opcode_next;
    logic [15:0]             r_operand, w_operand_next;
    logic                    r_cpu_reset, w_cpu_reset_next;
    logic                    r_done, w_done_next;
    logic                    r_error, w_error_next, w_hold_error;

    logic                    w_accept;
    logic                    w_timed;
    logic                    w_tmo_clear;
    logic                    w_expired;
    logic [15:0]             w_len;
    logic [RECORD_BYTES*8-1:0] w_rec_full;

    assign w_accept     = rx_valid && (r_state != ST_WRITE);
    assign w_timed      = is_timed(r_state);
    assign w_tmo_clear  = w_accept || !w_timed;
    assign w_len        = {r_remaining[15:8], rx_data};
    assign w_rec_full   = {r_rec, rx_data};
    // A silent cycle in a timed state either holds position or aborts the frame.
    assign w_hold_state = w_expired ? ST_ERROR : r_state;
    assign w_hold_error = w_expired | r_error;

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_timed),
        .o_expired (w_expired)
    );

    // Frame-parsing next-state and datapath update.
    always_comb begin
        w_state_next     = r_state;
        w_chk_next       = r_chk;
        w_remaining_next = r_remaining;
        w_rec_next       = r_rec;
        w_mem_we_next    = r_mem_we;
        w_addr_next      = r_addr;
        w_opcode_next    = r_opcode;
        w_operand_next   = r_operand;
        w_cpu_reset_next = r_cpu_reset;
        w_done_next      = r_done;
        w_error_next     = r_error;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_accept && (rx_data == MAGIC)) begin
                    w_state_next     = ST_LEN_HI;
                    w_chk_next       = 8'h00;
                    w_addr_next      = 16'h0000;
                    w_cpu_reset_next = 1'b1;
                    w_done_next      = 1'b0;
                    w_error_next     = 1'b0;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_LEN_HI: begin
                if (w_accept) begin
                    w_state_next     = ST_LEN_LO;
                    w_remaining_next = {rx_data, 8'h00};
                    w_chk_next       = chk_update(r_chk, rx_data);
                end else begin
                    w_state_next = w_hold_state;
                    w_error_next = w_hold_error;
                end
            end
            ST_LEN_LO: begin
                if (w_accept) begin
                    w_state_next     = (w_len == 16'h0000) ? ST_CHECK : ST_OPC_HI;
                    w_remaining_next = w_len;
                    w_chk_next       = chk_update(r_chk, rx_data);
                end else begin
                    w_state_next = w_hold_state;
                    w_error_next = w_hold_error;
                end
            end
            ST_OPC_HI, ST_OPC_LO, ST_OPR_HI: begin
                if (w_accept) begin
                    w_state_next = state_e'(r_state + 4'd1);
                    w_rec_next   = w_rec_full[PARTIAL_BITS-1:0];
                    w_chk_next   = chk_update(r_chk, rx_data);
                end else begin
                    w_state_next = w_hold_state;
                    w_error_next = w_hold_error;
                end
            end
            ST_OPR_LO: begin
                if (w_accept) begin
                    w_state_next   = ST_WRITE;
                    w_mem_we_next  = 1'b1;
                    w_opcode_next  = w_rec_full[31:16];
                    w_operand_next = w_rec_full[15:0];
                    w_chk_next     = chk_update(r_chk, rx_data);
                end else begin
                    w_state_next = w_hold_state;
                    w_error_next = w_hold_error;
                end
            end
            ST_WRITE: begin
                if (r_mem_we && mem_ready) begin
                    w_mem_we_next    = 1'b0;
                    w_addr_next      = r_addr + 16'd1;
                    w_remaining_next = r_remaining - 16'd1;
                    w_state_next     = (r_remaining == 16'd1) ? ST_CHECK : ST_OPC_HI;
                end else begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    if (rx_data == r_chk) begin
                        w_state_next     = ST_DONE;
                        w_done_next      = 1'b1;
                        w_cpu_reset_next = 1'b0;
                    end else begin
                        w_state_next = ST_ERROR;
                        w_error_next = 1'b1;
                    end
                end else begin
                    w_state_next = w_hold_state;
                    w_error_next = w_hold_error;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_chk       <= 8'h00;
            r_remaining <= 16'h0000;
            r_rec       <= '0;
            r_mem_we    <= 1'b0;
            r_addr      <= 16'h0000;
            r_opcode    <= 16'h0000;
            r_operand   <= 16'h0000;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_chk       <= w_chk_next;
            r_remaining <= w_remaining_next;
            r_rec       <= w_rec_next;
            r_mem_we    <= w_mem_we_next;
            r_addr      <= w_addr_next;
            r_opcode    <= w_opcode_next;
            r_operand   <= w_operand_next;
            r_cpu_reset <= w_cpu_reset_next;
            r_done      <= w_done_next;
            r_error     <= w_error_next;
        end
    end

    assign rx_ready    = (r_state != ST_WRITE);
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_addr;
    assign mem_opcode  = r_opcode;
    assign mem_operand = r_operand;
    assign cpu_reset   = r_cpu_reset;
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized
// frames judged against a frame-level reference model.
module tb_program_loader;

    localparam int         TMO   = 20;
    localparam logic [7:0] MAGIC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_opcode;
    logic [15:0] mem_operand;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    logic [47:0] got_q[$];
    logic [31:0] rec_q[$];
    bit          rand_ready = 1'b0;
    bit          rand_gaps  = 1'b0;

    program_loader #(
        .MAGIC   (MAGIC),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_opcode  (mem_opcode),
        .mem_operand (mem_operand),
        .cpu_reset   (cpu_reset),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && mem_we && mem_ready) got_q.push_back({mem_addr, mem_opcode, mem_operand});
    end

    always @(negedge clk) begin
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},  64'(rx_ready),    64'd1);
        check({tag, "_mem_we"},    64'(mem_we),      64'd0);
        check({tag, "_addr"},      64'(mem_addr),    64'd0);
        check({tag, "_opcode"},    64'(mem_opcode),  64'd0);
        check({tag, "_operand"},   64'(mem_operand), 64'd0);
        check({tag, "_cpu_reset"}, 64'(cpu_reset),   64'd1);
        check({tag, "_done"},      64'(done),        64'd0);
        check({tag, "_error"},     64'(error),       64'd0);
    endtask

    // Presents one byte until the loader takes it, then returns rx_valid low.
    task automatic send_byte(input logic [7:0] b);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        if (rand_gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        while (!acc && n < 200) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b;
            #1;
            acc = rx_ready;
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check("byte_accept", 64'(acc), 64'd1);
    endtask

    task automatic send_records(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            send_byte(rec_q[i][31:24]);
            send_byte(rec_q[i][23:16]);
            send_byte(rec_q[i][15:8]);
            send_byte(rec_q[i][7:0]);
        end
    endtask

    // Reference checksum: XOR of the two length bytes and every record byte.
    function automatic logic [7:0] ref_checksum();
        logic [15:0] len;
        logic [7:0]  c;
        len = 16'(rec_q.size());
        c   = len[15:8] ^ len[7:0];
        foreach (rec_q[i]) c = c ^ rec_q[i][31:24] ^ rec_q[i][23:16] ^ rec_q[i][15:8] ^ rec_q[i][7:0];
        return c;
    endfunction

    task automatic run_frame(input string tag, input bit corrupt);
        logic [7:0]  c;
        logic [15:0] len;
        len = 16'(rec_q.size());
        c   = ref_checksum();
        if (corrupt) c = c ^ 8'h5A;
        got_q.delete();
        send_byte(MAGIC);
        check({tag, "_start_done"},  64'(done),      64'd0);
        check({tag, "_start_error"}, 64'(error),     64'd0);
        check({tag, "_start_cpurst"}, 64'(cpu_reset), 64'd1);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        send_records(0, rec_q.size());
        send_byte(c);
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(rec_q.size()));
        for (int i = 0; i < rec_q.size() && i < got_q.size(); i++)
            check({tag, "_write"}, 64'(got_q[i]), 64'({16'(i), rec_q[i]}));
        check({tag, "_done"},      64'(done),      64'(!corrupt));
        check({tag, "_error"},     64'(error),     64'(corrupt));
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(corrupt));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;
        @(negedge clk);

        // Two-record frame, good and bad checksum.
        rec_q = '{32'h0001000A, 32'h0002000B};
        run_frame("frameA", 1'b0);
        run_frame("frameA_badchk", 1'b1);

        // Empty program: A5 00 00 00.
        rec_q.delete();
        run_frame("empty", 1'b0);

        // MAGIC values inside the frame are plain data.
        rec_q = '{32'hA5A5A5A5, 32'h00A5A500};
        run_frame("magic_data", 1'b0);

        // Memory back-pressure on the first record.
        rec_q = '{32'h0001000A, 32'h0002000B};
        got_q.delete();
        send_byte(MAGIC);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        mem_ready = 1'b0;
        send_byte(8'h0A);
        for (int i = 0; i < 5; i++) begin
            check("stall_we",       64'(mem_we),      64'd1);
            check("stall_rx_ready", 64'(rx_ready),    64'd0);
            check("stall_addr",     64'(mem_addr),    64'h0000);
            check("stall_opcode",   64'(mem_opcode),  64'h0001);
            check("stall_operand",  64'(mem_operand), 64'h000A);
            @(negedge clk);
        end
        check("stall_we_last", 64'(mem_we), 64'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        check("stall_we_drop",  64'(mem_we),        64'd0);
        check("stall_addr_inc", 64'(mem_addr),      64'h0001);
        check("stall_nwrites1", 64'(got_q.size()),  64'd1);
        send_records(1, 2);
        send_byte(ref_checksum());
        check("stall_nwrites2", 64'(got_q.size()), 64'd2);
        if (got_q.size() > 1) check("stall_write1", 64'(got_q[1]), 64'h0001_0002_000B);
        check("stall_done", 64'(done), 64'd1);

        // Sender goes silent after the length field.
        rec_q = '{32'h12345678};
        send_byte(MAGIC);
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_before_error", 64'(error), 64'd0);
        @(negedge clk);
        check("tmo_error",     64'(error),     64'd1);
        check("tmo_done",      64'(done),      64'd0);
        check("tmo_cpu_reset", 64'(cpu_reset), 64'd1);
        run_frame("after_tmo", 1'b0);

        // Reset while waiting for OPR_HI of record 1.
        rec_q = '{32'hCAFE0001, 32'hBEEF0002};
        got_q.delete();
        send_byte(MAGIC);
        send_byte(8'h00);
        send_byte(8'h02);
        send_records(0, 1);
        send_byte(8'hBE);
        send_byte(8'hEF);
        check("rstf_nwrites", 64'(got_q.size()), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_values("rst_frame");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_frame("post_reset", 1'b0);

        // Reset while a write is pending.
        rec_q = '{32'h11112222};
        send_byte(MAGIC);
        send_byte(8'h00);
        send_byte(8'h01);
        mem_ready = 1'b0;
        send_records(0, 1);
        check("rstw_we_pending", 64'(mem_we), 64'd1);
        got_q.delete();
        reset = 1'b0;
        #1;
        check_reset_values("rst_write");
        @(negedge clk);
        mem_ready = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        check("rstw_no_write", 64'(got_q.size()), 64'd0);

        // Randomized frames with random memory stalls and byte gaps.
        rand_ready = 1'b1;
        rand_gaps  = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(0, 5);
            rec_q.delete();
            for (int k = 0; k < n; k++) rec_q.push_back($urandom);
            run_frame("rand", 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        rand_gaps  = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
